// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one single-port register file between
// NUM_REQ requesters; clears win over accesses.
module regfile_access_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_a,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data_1,
  output logic [DATA_WIDTH-1:0]         rsp_data_2,
  input  logic                          clear_req,
  output logic                          clear_done,
  output logic                          busy,
  output logic                          rf_enable,
  output logic                          rf_read,
  output logic                          rf_write,
  output logic                          rf_reset,
  output logic [ADDR_WIDTH-1:0]         rf_select_input,
  output logic [ADDR_WIDTH-1:0]         rf_select_output_1,
  output logic [ADDR_WIDTH-1:0]         rf_select_output_2,
  output logic [DATA_WIDTH-1:0]         rf_in,
  input  logic [DATA_WIDTH-1:0]         rf_data_1,
  input  logic [DATA_WIDTH-1:0]         rf_data_2
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [ADDR_WIDTH-1:0] addr_a_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_b_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a_arr[g] = req_addr_a[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_b_arr[g] = req_addr_b[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g]  = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         own_q, own_d;
  logic                  wr_q, wr_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [NUM_REQ-1:0]    rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic [DATA_WIDTH-1:0] d2_q, d2_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  en_q, en_d;
  logic                  rd_q, rd_d;
  logic                  wrs_q, wrs_d;
  logic                  rst_q, rst_d;
  logic [ADDR_WIDTH-1:0] sin_q, sin_d;
  logic [ADDR_WIDTH-1:0] so1_q, so1_d;
  logic [ADDR_WIDTH-1:0] so2_q, so2_d;
  logic [DATA_WIDTH-1:0] rfin_q, rfin_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan;

  // Scan starts one past the last winner and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = (scan == PW'(NUM_REQ - 1)) ? '0 : scan + PW'(1);
      if (!win_found && req_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wr_d    = wr_q;
    ready_d = '0;
    rsp_d   = '0;
    d1_d    = d1_q;
    d2_d    = d2_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    rd_d    = 1'b0;
    wrs_d   = 1'b0;
    rst_d   = 1'b0;
    sin_d   = '0;
    so1_d   = '0;
    so2_d   = '0;
    rfin_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          en_d    = 1'b1;
          rst_d   = 1'b1;
        end else if (win_found) begin
          state_d          = S_ISSUE;
          ptr_d            = win_idx;
          own_d            = win_idx;
          wr_d             = req_write[win_idx];
          ready_d[win_idx] = 1'b1;
          en_d             = 1'b1;
          if (req_write[win_idx]) begin
            wrs_d  = 1'b1;
            sin_d  = addr_a_arr[win_idx];
            rfin_d = wdata_arr[win_idx];
          end else begin
            rd_d  = 1'b1;
            so1_d = addr_a_arr[win_idx];
            so2_d = addr_b_arr[win_idx];
          end
        end
      end
      S_CLEAR: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (wr_q) begin
          rsp_d[own_q] = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        d1_d         = rf_data_1;
        d2_d         = rf_data_2;
        rsp_d[own_q] = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      own_q   <= '0;
      wr_q    <= 1'b0;
      ready_q <= '0;
      rsp_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      wrs_q   <= 1'b0;
      rst_q   <= 1'b0;
      sin_q   <= '0;
      so1_q   <= '0;
      so2_q   <= '0;
      rfin_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
      en_q    <= en_d;
      rd_q    <= rd_d;
      wrs_q   <= wrs_d;
      rst_q   <= rst_d;
      sin_q   <= sin_d;
      so1_q   <= so1_d;
      so2_q   <= so2_d;
      rfin_q  <= rfin_d;
    end
  end

  assign req_ready          = ready_q;
  assign rsp_valid          = rsp_q;
  assign rsp_data_1         = d1_q;
  assign rsp_data_2         = d2_q;
  assign clear_done         = done_q;
  assign busy               = busy_q;
  assign rf_enable          = en_q;
  assign rf_read            = rd_q;
  assign rf_write           = wrs_q;
  assign rf_reset           = rst_q;
  assign rf_select_input    = sin_q;
  assign rf_select_output_1 = so1_q;
  assign rf_select_output_2 = so2_q;
  assign rf_in              = rfin_q;

endmodule
